// File: rtl/hazard_alarm_ctrl.sv
// hazard_alarm_ctrl: shares one siren between fire, gas and intrusion sensors.
// Each raw sensor is debounced, requests are arbitrated by fixed priority
// (fire > gas > intrusion), and an FSM sequences ALARM / SILENCED / IDLE.
// Optional build macro ALARM_PATTERN_EN: pulses the siren in ALARM with a
// per-source on/off pattern counted in PATTERN_PERIOD-cycle units. Without
// the macro the siren is steady in ALARM and no phase logic exists.
//
// state      | meaning
// S_IDLE     | no qualified request, siren off
// S_ALARM    | siren driven for the highest-priority request
// S_SILENCED | user acked, siren muted until timer expires or a higher source appears
module hazard_alarm_ctrl #(
  parameter int DEBOUNCE       = 4,
  parameter int SILENCE_CYCLES = 16
`ifdef ALARM_PATTERN_EN
  , parameter int PATTERN_PERIOD = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_sensor,
  input  logic       g_sensor,
  input  logic       i_sensor,
  input  logic       arm,
  input  logic       ack,
  output logic       siren,
  output logic [1:0] alarm_src,
  output logic       f_alarm,
  output logic       g_alarm,
  output logic       i_alarm,
  output logic       silenced
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int TW  = $clog2(SILENCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ALARM    = 2'd1,
    S_SILENCED = 2'd2
  } state_t;

  // index 0 = fire, 1 = gas, 2 = intrusion
  logic [2:0]     raw;
  logic [2:0]     lvl_q, lvl_d;
  logic [DBW-1:0] dcnt_q [3];
  logic [DBW-1:0] dcnt_d [3];
  logic           ia_q;

  state_t         state_q;
  logic           siren_q;
  logic [1:0]     src_q;
  logic           sil_q;
  logic [TW-1:0]  tmr_q;

  logic [1:0]     winner;
  logic           preempt;
  logic           pat_on;

  assign raw = {i_sensor, g_sensor, f_sensor};

  // Debounce: count consecutive disagreeing samples, flip the level when the run reaches DEBOUNCE.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lvl_d[i]  = lvl_q[i];
      dcnt_d[i] = '0;
      if (raw[i] != lvl_q[i]) begin
        if (dcnt_q[i] == DBW'(DEBOUNCE - 1)) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // Debounce state and the arm-qualified intrusion level.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
      ia_q  <= 1'b0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      lvl_q <= lvl_d;
      ia_q  <= lvl_d[2] & arm;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Fixed-priority arbitration; a smaller non-zero code means higher priority.
  always_comb begin
    winner = 2'd0;
    if (lvl_q[0])      winner = 2'd1;
    else if (lvl_q[1]) winner = 2'd2;
    else if (ia_q)     winner = 2'd3;
    preempt = (winner != 2'd0) && (winner < src_q);
  end

`ifdef ALARM_PATTERN_EN
  localparam int PPW = $clog2(PATTERN_PERIOD + 1);

  logic [PPW-1:0] pp_q;
  logic [3:0]     seg_q, seg_nxt;

  // Segment index runs 0..11 (common multiple of the 2/6/4-segment patterns).
  function automatic logic pat_level(input logic [1:0] src, input logic [3:0] seg);
    case (src)
      2'd1:    pat_level = ~seg[0];
      2'd2:    pat_level = (seg < 4'd3) || ((seg >= 4'd6) && (seg < 4'd9));
      2'd3:    pat_level = (seg == 4'd0) || (seg == 4'd4) || (seg == 4'd8);
      default: pat_level = 1'b0;
    endcase
  endfunction

  // Next siren level while ALARM holds the same source.
  always_comb begin
    seg_nxt = (seg_q == 4'd11) ? 4'd0 : seg_q + 4'd1;
    pat_on  = (pp_q == PPW'(PATTERN_PERIOD - 1)) ? pat_level(src_q, seg_nxt) : siren_q;
  end

  // Phase counter restarts outside ALARM and on any source change.
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_ALARM) || (winner != src_q)) begin
      pp_q  <= '0;
      seg_q <= '0;
    end else if (pp_q == PPW'(PATTERN_PERIOD - 1)) begin
      pp_q  <= '0;
      seg_q <= seg_nxt;
    end else begin
      pp_q  <= pp_q + PPW'(1);
    end
  end
`else
  assign pat_on = 1'b1;
`endif

  // Alarm sequencer with registered siren / source / silenced outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      siren_q <= 1'b0;
      src_q   <= 2'd0;
      sil_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (winner != 2'd0) begin
            state_q <= S_ALARM;
            src_q   <= winner;
            siren_q <= 1'b1;
          end
        end
        S_ALARM: begin
          if (winner == 2'd0) begin
            state_q <= S_IDLE;
            src_q   <= 2'd0;
            siren_q <= 1'b0;
          end else if (ack && !preempt) begin
            state_q <= S_SILENCED;
            src_q   <= winner;
            siren_q <= 1'b0;
            sil_q   <= 1'b1;
            tmr_q   <= TW'(SILENCE_CYCLES);
          end else begin
            src_q   <= winner;
            siren_q <= (winner != src_q) ? 1'b1 : pat_on;
          end
        end
        S_SILENCED: begin
          if (preempt) begin
            state_q <= S_ALARM;
            src_q   <= winner;
            siren_q <= 1'b1;
            sil_q   <= 1'b0;
            tmr_q   <= '0;
          end else if (winner == 2'd0) begin
            state_q <= S_IDLE;
            src_q   <= 2'd0;
            sil_q   <= 1'b0;
            tmr_q   <= '0;
          end else if (ack) begin
            tmr_q   <= TW'(SILENCE_CYCLES);
          end else if (tmr_q <= TW'(1)) begin
            // timer reaches zero on this edge
            state_q <= S_ALARM;
            src_q   <= winner;
            siren_q <= 1'b1;
            sil_q   <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q   <= tmr_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          siren_q <= 1'b0;
          src_q   <= 2'd0;
          sil_q   <= 1'b0;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign siren     = siren_q;
  assign alarm_src = src_q;
  assign f_alarm   = lvl_q[0];
  assign g_alarm   = lvl_q[1];
  assign i_alarm   = ia_q;
  assign silenced  = sil_q;

endmodule

// File: tb/tb_hazard_alarm_ctrl.sv
// Bench for hazard_alarm_ctrl (default build, steady siren).
module tb_hazard_alarm_ctrl;

  localparam int DEB = 4;
  localparam int SIL = 16;

  logic       clk = 1'b0;
  logic       rst, f_sensor, g_sensor, i_sensor, arm, ack;
  logic       siren;
  logic [1:0] alarm_src;
  logic       f_alarm, g_alarm, i_alarm, silenced;

  always #5 clk = ~clk;

  hazard_alarm_ctrl #(.DEBOUNCE(DEB), .SILENCE_CYCLES(SIL)) dut (
    .clk(clk), .rst(rst),
    .f_sensor(f_sensor), .g_sensor(g_sensor), .i_sensor(i_sensor),
    .arm(arm), .ack(ack),
    .siren(siren), .alarm_src(alarm_src),
    .f_alarm(f_alarm), .g_alarm(g_alarm), .i_alarm(i_alarm),
    .silenced(silenced)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: run lengths per sensor, a mode number and a countdown.
  bit [2:0] m_lvl;
  int       m_run [3];
  bit       m_ia;
  int       m_mode;   // 0 idle, 1 alarm, 2 silenced
  int       m_src;
  bit       m_siren, m_sil;
  int       m_rem;

  function automatic logic [6:0] dut_out();
    return {siren, alarm_src, f_alarm, g_alarm, i_alarm, silenced};
  endfunction

  function automatic logic [6:0] m_out();
    logic [1:0] s;
    s = 2'(m_src);
    return {m_siren, s, m_lvl[0], m_lvl[1], m_ia, m_sil};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (siren,src,f,g,i,silenced)", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic model_step();
    int win;
    bit raw;
    bit [2:0] req;
    if (rst) begin
      m_lvl = '0; m_ia = 0; m_mode = 0; m_src = 0; m_siren = 0; m_sil = 0; m_rem = 0;
      for (int s = 0; s < 3; s++) m_run[s] = 0;
      return;
    end
    req = {m_ia, m_lvl[1], m_lvl[0]};
    win = 0;
    for (int s = 2; s >= 0; s--) if (req[s]) win = s + 1;
    case (m_mode)
      0: if (win != 0) begin m_mode = 1; m_src = win; m_siren = 1; end
      1: begin
        if (win == 0) begin m_mode = 0; m_src = 0; m_siren = 0; end
        else if (ack && !(win < m_src)) begin
          m_mode = 2; m_src = win; m_siren = 0; m_sil = 1; m_rem = SIL;
        end else m_src = win;
      end
      default: begin
        if (win != 0 && win < m_src) begin m_mode = 1; m_src = win; m_siren = 1; m_sil = 0; end
        else if (win == 0) begin m_mode = 0; m_src = 0; m_sil = 0; end
        else if (ack) m_rem = SIL;
        else begin
          m_rem--;
          if (m_rem == 0) begin m_mode = 1; m_src = win; m_siren = 1; m_sil = 0; end
        end
      end
    endcase
    for (int s = 0; s < 3; s++) begin
      raw = (s == 0) ? f_sensor : (s == 1) ? g_sensor : i_sensor;
      if (raw == m_lvl[s]) m_run[s] = 0;
      else begin
        m_run[s]++;
        if (m_run[s] >= DEB) begin m_lvl[s] = !m_lvl[s]; m_run[s] = 0; end
      end
    end
    m_ia = m_lvl[2] && arm;
  endtask

  task automatic drive(input logic r, fs, gs, is, a, k);
    rst = r; f_sensor = fs; g_sensor = gs; i_sensor = is; arm = a; ack = k;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out(), m_out());
  endtask

  typedef struct {
    logic r, f, g, i, a, k;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic r, f, g, i, a, k, input logic [6:0] exp);
    vec_t v;
    v.r = r; v.f = f; v.g = g; v.i = i; v.a = a; v.k = k; v.exp = exp;
    return v;
  endfunction

  bit ok;
  bit rf, rg, ri, ra;

  initial begin
    // outputs as {siren, src[1:0], f_alarm, g_alarm, i_alarm, silenced}
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 7'b0000000);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 7'b0000000);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 7'b0000000);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 7'b0000000);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 7'b0000000);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 7'b0001000);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 7'b1011000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 7'b1011000);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 7'b1011000);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 7'b1011000);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 7'b1010000);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 7'b0000000);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 7'b0000000);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 7'b0000000);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 7'b0000000);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 7'b0000000);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 7'b0000000);

    drive(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 17; n++) begin
      drive(tbl[n].r, tbl[n].f, tbl[n].g, tbl[n].i, tbl[n].a, tbl[n].k);
      step();
      check($sformatf("vec%0d", n), dut_out(), tbl[n].exp);
    end

    // Gas alarm preempted by fire, siren without gap
    drive(0, 0, 1, 0, 0, 0);
    repeat (5) step();
    check_bit("gas_siren", siren, 1'b1);
    check("gas_src", {5'b0, alarm_src}, 7'd2);
    drive(0, 1, 1, 0, 0, 0);
    ok = 1;
    repeat (4) begin step(); if (siren !== 1'b1) ok = 0; end
    check("gas_src_held", {5'b0, alarm_src}, 7'd2);
    step();
    if (siren !== 1'b1) ok = 0;
    check("preempt_src", {5'b0, alarm_src}, 7'd1);
    check_bit("preempt_no_gap", ok, 1'b1);

    // Silence fire, siren returns after 16 cycles
    drive(0, 1, 1, 0, 0, 1);
    step();
    drive(0, 1, 1, 0, 0, 0);
    check_bit("ack_silenced", silenced, 1'b1);
    check_bit("ack_siren_off", siren, 1'b0);
    ok = 1;
    repeat (15) begin step(); if (siren !== 1'b0 || silenced !== 1'b1) ok = 0; end
    check_bit("silence_held", ok, 1'b1);
    step();
    check("silence_expire", {siren, alarm_src, silenced}, {4'b1010, 3'b0} >> 3);

    // Silence again, then all sensors drop -> IDLE
    drive(0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check_bit("ack2_silenced", silenced, 1'b1);
    repeat (4) step();
    check("drop_idle", dut_out(), 7'b0000000);

    // ack in IDLE ignored
    drive(0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("ack_idle", dut_out(), 7'b0000000);

    // Silenced gas, fire request together with ack: preemption wins
    drive(0, 0, 1, 0, 0, 0);
    repeat (5) step();
    drive(0, 0, 1, 0, 0, 1);
    step();
    check("gas_silenced", {siren, alarm_src, silenced}, 4'b0101);
    drive(0, 1, 1, 0, 0, 0);
    repeat (4) step();
    check_bit("still_silenced", silenced, 1'b1);
    drive(0, 1, 1, 0, 0, 1);
    step();
    drive(0, 1, 1, 0, 0, 0);
    check("preempt_ack", {siren, alarm_src, silenced}, 4'b1010);
    step();
    check("preempt_ack_hold", {siren, alarm_src, silenced}, 4'b1010);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Intrusion gated by arm, arm falling, reset mid-alarm
    drive(0, 0, 0, 1, 0, 0);
    repeat (6) step();
    check("disarmed", {siren, i_alarm}, 2'b00);
    drive(0, 0, 0, 1, 1, 0);
    step();
    check_bit("arm_i_alarm", i_alarm, 1'b1);
    step();
    check("intr_src", {siren, alarm_src}, 3'b111);
    drive(0, 0, 0, 1, 0, 0);
    step();
    check("disarm_i", {i_alarm, alarm_src}, 3'b011);
    step();
    check("disarm_idle", {siren, alarm_src}, 3'b000);
    drive(0, 0, 0, 1, 1, 0);
    repeat (2) step();
    check("rearm_src", {siren, alarm_src}, 3'b111);
    drive(1, 0, 0, 1, 1, 0);
    step();
    check("rst_mid", dut_out(), 7'b0000000);
    drive(0, 0, 0, 1, 1, 0);
    repeat (4) step();
    check("post_rst_deb", {siren, i_alarm}, 2'b01);
    step();
    check("post_rst_alarm", {siren, alarm_src}, 3'b111);

    // Randomized run against the model
    rf = 0; rg = 0; ri = 1; ra = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0)  rf = !rf;
      if ($urandom_range(7) == 0)  rg = !rg;
      if ($urandom_range(5) == 0)  ri = !ri;
      if ($urandom_range(31) == 0) ra = !ra;
      drive(($urandom_range(299) == 0), rf, rg, ri, ra, ($urandom_range(9) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
